// File: rtl/trap_ctrl.sv
// Trap sequencer: takes exceptions and MRET from writeback, flushes, writes CSRs, redirects fetch.
// Optional interrupt entry is enabled by defining TRAP_IRQ_EN.
module trap_ctrl #(
  parameter int unsigned       XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            exc_valid_i,
  input  logic [5:0]      exc_flags_i,
  input  logic            mret_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] badaddr_i,
  input  logic            pipe_empty_i,
  input  logic [XLEN-1:0] csr_target_i,
  input  logic [XLEN-1:0] mstatus_i,
  input  logic [XLEN-1:0] mcause_i,
  input  logic [XLEN-1:0] mtval_i,
`ifdef TRAP_IRQ_EN
  input  logic            irq_timer_i,
  input  logic            irq_ext_i,
  input  logic [XLEN-1:0] mie_i,
`endif
  output logic            busy_o,
  output logic            flush_o,
  output logic            we_exc_o,
  output logic [XLEN-1:0] mcause_o,
  output logic [XLEN-1:0] mepc_o,
  output logic [XLEN-1:0] mtval_o,
  output logic [XLEN-1:0] mstatus_o,
  output logic            aux_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o
);

  typedef enum logic [2:0] {StIdle, StMretRd, StFlush, StWrite, StRedirect} state_e;

  state_e          state_q;
  logic            is_mret_q;
  logic [XLEN-1:0] cause_q, epc_q, tval_q, mstat_q;

  logic [XLEN-1:0] exc_cause, exc_tval, trap_mstatus, mret_mstatus;
  logic            irq_take;
  logic [XLEN-1:0] irq_cause;

`ifdef TRAP_IRQ_EN
  always_comb begin
    irq_take  = 1'b0;
    irq_cause = '0;
    if (mstatus_i[3]) begin
      if (irq_ext_i && mie_i[11]) begin
        irq_take  = 1'b1;
        irq_cause = 32'h8000_000B;
      end else if (irq_timer_i && mie_i[7]) begin
        irq_take  = 1'b1;
        irq_cause = 32'h8000_0007;
      end
    end
  end
`else
  assign irq_take  = 1'b0;
  assign irq_cause = '0;
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^pc_i[1:0];
`endif

  always_comb begin
    // No flag set is reported as an illegal instruction.
    exc_cause = 32'd2;
    exc_tval  = instr_i;
    if (exc_flags_i[0]) begin
      exc_cause = 32'd0;
      exc_tval  = badaddr_i;
    end else if (exc_flags_i[1]) begin
      exc_cause = 32'd2;
      exc_tval  = instr_i;
    end else if (exc_flags_i[4]) begin
      exc_cause = 32'd3;
      exc_tval  = '0;
    end else if (exc_flags_i[5]) begin
      exc_cause = 32'd11;
      exc_tval  = '0;
    end else if (exc_flags_i[3]) begin
      exc_cause = 32'd6;
      exc_tval  = badaddr_i;
    end else if (exc_flags_i[2]) begin
      exc_cause = 32'd4;
      exc_tval  = badaddr_i;
    end
    trap_mstatus        = mstatus_i;
    trap_mstatus[7]     = mstatus_i[3];
    trap_mstatus[3]     = 1'b0;
    trap_mstatus[12:11] = 2'b11;
    mret_mstatus        = mstatus_i;
    mret_mstatus[3]     = mstatus_i[7];
    mret_mstatus[7]     = 1'b1;
    mret_mstatus[12:11] = 2'b11;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      is_mret_q     <= 1'b0;
      cause_q       <= '0;
      epc_q         <= '0;
      tval_q        <= '0;
      mstat_q       <= '0;
      mcause_o      <= '0;
      mepc_o        <= '0;
      mtval_o       <= '0;
      mstatus_o     <= '0;
      redirect_pc_o <= RESET_PC;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (exc_valid_i) begin
            cause_q   <= exc_cause;
            epc_q     <= {pc_i[XLEN-1:2], 2'b00};
            tval_q    <= exc_tval;
            mstat_q   <= trap_mstatus;
            is_mret_q <= 1'b0;
            state_q   <= StFlush;
          end else if (mret_i) begin
            mstat_q   <= mret_mstatus;
            is_mret_q <= 1'b1;
            state_q   <= StMretRd;
          end else if (irq_take) begin
            cause_q   <= irq_cause;
            epc_q     <= pc_i;
            tval_q    <= '0;
            mstat_q   <= trap_mstatus;
            is_mret_q <= 1'b0;
            state_q   <= StFlush;
          end
        end
        StMretRd: begin
          // aux_o is high here, so csr_target_i carries mepc.
          epc_q   <= csr_target_i;
          cause_q <= mcause_i;
          tval_q  <= mtval_i;
          state_q <= StFlush;
        end
        StFlush: begin
          if (pipe_empty_i) begin
            mcause_o  <= cause_q;
            mepc_o    <= epc_q;
            mtval_o   <= tval_q;
            mstatus_o <= mstat_q;
            state_q   <= StWrite;
          end
        end
        StWrite: begin
          redirect_pc_o <= is_mret_q ? epc_q : {csr_target_i[XLEN-1:2], 2'b00};
          state_q       <= StRedirect;
        end
        StRedirect: state_q <= StIdle;
        default:    state_q <= StIdle;
      endcase
    end
  end

  assign busy_o           = (state_q != StIdle);
  assign flush_o          = (state_q == StFlush);
  assign we_exc_o         = (state_q == StWrite);
  assign redirect_valid_o = (state_q == StRedirect);
  assign aux_o            = (state_q == StMretRd);

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: vector table, CSR-write/redirect scoreboard, flush and reset corner cases.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exc_valid = 1'b0, mret = 1'b0, pipe_empty = 1'b1;
  logic [5:0]  flags = '0;
  logic [31:0] pc = '0, instr = '0, badaddr = '0, mstatus = '0, mcause_in = '0, mtval_in = '0;
  logic [31:0] tb_mepc = '0, tb_mtvec = '0;
  logic [31:0] csr_target;
  logic        busy, flush, we_exc, aux, redir_valid;
  logic [31:0] mcause_o, mepc_o, mtval_o, mstatus_o, redir_pc;
`ifdef TRAP_IRQ_EN
  logic        irq_timer = 1'b0, irq_ext = 1'b0;
  logic [31:0] mie = '0;
`endif

  assign csr_target = aux ? tb_mepc : tb_mtvec;

  always #5 clk = ~clk;

  trap_ctrl dut (
    .clk_i(clk), .rst_i(rst), .exc_valid_i(exc_valid), .exc_flags_i(flags), .mret_i(mret),
    .pc_i(pc), .instr_i(instr), .badaddr_i(badaddr), .pipe_empty_i(pipe_empty),
    .csr_target_i(csr_target), .mstatus_i(mstatus), .mcause_i(mcause_in), .mtval_i(mtval_in),
`ifdef TRAP_IRQ_EN
    .irq_timer_i(irq_timer), .irq_ext_i(irq_ext), .mie_i(mie),
`endif
    .busy_o(busy), .flush_o(flush), .we_exc_o(we_exc), .mcause_o(mcause_o), .mepc_o(mepc_o),
    .mtval_o(mtval_o), .mstatus_o(mstatus_o), .aux_o(aux), .redirect_valid_o(redir_valid),
    .redirect_pc_o(redir_pc)
  );

  typedef struct {
    logic [31:0] cause, epc, tval, mst;
  } wr_t;

  typedef struct {
    logic        exc_valid;
    logic [5:0]  flags;
    logic        mret;
    logic [31:0] pc, instr, badaddr, mstatus, mcause_in, mtval_in, mepc_csr, mtvec;
    logic [31:0] e_cause, e_epc, e_tval, e_mst, e_redir;
    int          e_lat;
  } vec_t;

  wr_t         wq[$];
  logic [31:0] rq[$];
  int          checks = 0, errors = 0, we_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every CSR write and redirect must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && we_exc) begin
      wr_t e;
      we_seen++;
      if (wq.size() == 0) begin
        chk("unexpected_we_exc", 32'd1, 32'd0);
      end else begin
        e = wq.pop_front();
        chk("mcause", mcause_o, e.cause);
        chk("mepc", mepc_o, e.epc);
        chk("mtval", mtval_o, e.tval);
        chk("mstatus", mstatus_o, e.mst);
      end
    end
    if (!rst && redir_valid) begin
      if (rq.size() == 0) chk("unexpected_redirect", 32'd1, 32'd0);
      else chk("redirect_pc", redir_pc, rq.pop_front());
    end
  end

  task automatic wait_redirect(output int n);
    n = 1;
    while (!redir_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    @(negedge clk);
    exc_valid = v.exc_valid; flags = v.flags; mret = v.mret; pc = v.pc; instr = v.instr;
    badaddr = v.badaddr; mstatus = v.mstatus; mcause_in = v.mcause_in; mtval_in = v.mtval_in;
    tb_mepc = v.mepc_csr; tb_mtvec = v.mtvec; pipe_empty = 1'b1;
    wq.push_back('{v.e_cause, v.e_epc, v.e_tval, v.e_mst});
    rq.push_back(v.e_redir);
    @(negedge clk);
    exc_valid = 1'b0; mret = 1'b0;
    chk("busy_after_sample", {31'd0, busy}, 32'd1);
    wait_redirect(n);
    chk("latency", n, v.e_lat);
    @(negedge clk);
    chk("idle_after", {31'd0, busy}, 32'd0);
  endtask

  vec_t vecs[10];

  initial begin
    int n, fl;
    //          ev flags      mr pc          instr         badaddr       mstatus       mcause_in mtval_in      mepc_csr      mtvec
    //          exp cause  exp epc   exp tval      exp mstatus   exp redir    lat
    vecs[0] = '{1'b1, 6'b000010, 1'b0, 32'h100, 32'hFFFF_FFFF, 32'h0, 32'h8, 32'h0, 32'h0, 32'h0,
                32'h200, 32'd2, 32'h100, 32'hFFFF_FFFF, 32'h1880, 32'h200, 3};
    vecs[1] = '{1'b1, 6'b100001, 1'b0, 32'h104, 32'h13, 32'h3, 32'h0, 32'h0, 32'h0, 32'h0,
                32'h200, 32'd0, 32'h104, 32'h3, 32'h1800, 32'h200, 3};
    vecs[2] = '{1'b1, 6'b110000, 1'b0, 32'h20B, 32'h0010_0073, 32'h55, 32'hFFFF_FFFF, 32'h0,
                32'h0, 32'h0, 32'h303, 32'd3, 32'h208, 32'h0, 32'hFFFF_FFF7, 32'h300, 3};
    vecs[3] = '{1'b1, 6'b101000, 1'b0, 32'h400, 32'h73, 32'h66, 32'h88, 32'h0, 32'h0, 32'h0,
                32'h200, 32'd11, 32'h400, 32'h0, 32'h1880, 32'h200, 3};
    vecs[4] = '{1'b1, 6'b001100, 1'b0, 32'h500, 32'h23, 32'h1001, 32'h1800, 32'h0, 32'h0, 32'h0,
                32'h200, 32'd6, 32'h500, 32'h1001, 32'h1800, 32'h200, 3};
    vecs[5] = '{1'b1, 6'b000100, 1'b0, 32'h600, 32'h03, 32'h2002, 32'h80, 32'h0, 32'h0, 32'h0,
                32'h200, 32'd4, 32'h600, 32'h2002, 32'h1800, 32'h200, 3};
    vecs[6] = '{1'b1, 6'b000000, 1'b0, 32'h50, 32'hDEAD_BEEF, 32'h0, 32'h8, 32'h0, 32'h0, 32'h0,
                32'h200, 32'd2, 32'h50, 32'hDEAD_BEEF, 32'h1880, 32'h200, 3};
    vecs[7] = '{1'b1, 6'b000001, 1'b1, 32'h700, 32'h0, 32'h7, 32'h0, 32'h0, 32'h0, 32'h999,
                32'h200, 32'd0, 32'h700, 32'h7, 32'h1800, 32'h200, 3};
    vecs[8] = '{1'b0, 6'b000000, 1'b1, 32'h800, 32'h3020_0073, 32'h0, 32'h1880, 32'd2,
                32'hFFFF_FFFF, 32'h104, 32'h200, 32'd2, 32'h104, 32'hFFFF_FFFF, 32'h1888, 32'h104, 4};
    vecs[9] = '{1'b0, 6'b000000, 1'b1, 32'h900, 32'h3020_0073, 32'h0, 32'h0, 32'd11, 32'h0,
                32'h1002, 32'h200, 32'd11, 32'h1002, 32'h0, 32'h1880, 32'h1002, 4};

    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_redirect_pc", redir_pc, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_flush", {31'd0, flush}, 32'd0);
    chk("reset_we", {31'd0, we_exc}, 32'd0);
    chk("reset_aux", {31'd0, aux}, 32'd0);
    chk("reset_redir_valid", {31'd0, redir_valid}, 32'd0);
    chk("reset_mcause", mcause_o, 32'h0);
    chk("reset_redirect_pc", redir_pc, 32'h0);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Pipeline stays busy for five flush cycles; the sixth sees it drained.
    @(negedge clk);
    exc_valid = 1'b1; flags = 6'b000010; pc = 32'hA00; instr = 32'h1234_5678; mstatus = 32'h8;
    tb_mtvec = 32'h400; pipe_empty = 1'b0;
    wq.push_back('{32'd2, 32'hA00, 32'h1234_5678, 32'h1880});
    rq.push_back(32'h400);
    @(negedge clk);
    exc_valid = 1'b0;
    fl = 0;
    for (int c = 0; c < 20 && flush; c++) begin
      fl++;
      chk("flush_busy", {31'd0, busy}, 32'd1);
      chk("flush_no_we", {31'd0, we_exc}, 32'd0);
      if (fl == 6) pipe_empty = 1'b1;
      @(negedge clk);
    end
    chk("flush_cycles", fl, 32'd6);
    chk("we_after_flush", {31'd0, we_exc}, 32'd1);
    wait_redirect(n);
    chk("flush_redirect_seen", {31'd0, redir_valid}, 32'd1);
    @(negedge clk);

    // Reset during FLUSH must abort without any CSR write.
    n = we_seen;
    exc_valid = 1'b1; flags = 6'b000001; badaddr = 32'h11; pipe_empty = 1'b0;
    @(negedge clk);
    exc_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_flush", {31'd0, flush}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pipe_empty = 1'b1;
    chk("post_reset_redirect_pc", redir_pc, 32'h0);
    repeat (5) @(negedge clk);
    chk("post_reset_busy", {31'd0, busy}, 32'd0);
    chk("no_we_after_reset", we_seen, n);

`ifdef TRAP_IRQ_EN
    mie = 32'h80; irq_timer = 1'b1; mstatus = 32'h8; pc = 32'hB02; tb_mtvec = 32'h200;
    wq.push_back('{32'h8000_0007, 32'hB02, 32'h0, 32'h1880});
    rq.push_back(32'h200);
    @(negedge clk);
    mstatus = 32'h0;
    wait_redirect(n);
    chk("irq_latency", n, 32'd3);
    @(negedge clk);
    irq_timer = 1'b1; mstatus = 32'h0;
    repeat (4) @(negedge clk);
    chk("irq_masked_busy", {31'd0, busy}, 32'd0);
    irq_timer = 1'b0;
`endif

    repeat (3) @(negedge clk);
    chk("wq_drained", wq.size(), 32'd0);
    chk("rq_drained", rq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

endmodule
